// File: rtl/mips8_mc_controller.sv
// Multicycle control FSM for the 8-bit MIPS datapath.
// Fetches four instruction bytes, decodes op, sequences datapath enables.
module mips8_mc_controller #(
   parameter int OPW = 6,
   parameter int SW  = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [OPW-1:0] op,
   input  logic           zero,
   output logic           memread,
   output logic           memwrite,
   output logic           alusrca,
   output logic           memtoreg,
   output logic           iord,
   output logic           pcen,
   output logic           regwrite,
   output logic           regdst,
   output logic [1:0]     pcsource,
   output logic [1:0]     alusrcb,
   output logic [1:0]     aluop,
   output logic [3:0]     irwrite,
   output logic [SW-1:0]  state
);

   localparam logic [SW-1:0] FETCH1  = 4'd0;
   localparam logic [SW-1:0] FETCH2  = 4'd1;
   localparam logic [SW-1:0] FETCH3  = 4'd2;
   localparam logic [SW-1:0] FETCH4  = 4'd3;
   localparam logic [SW-1:0] DECODE  = 4'd4;
   localparam logic [SW-1:0] MEMADR  = 4'd5;
   localparam logic [SW-1:0] LBRD    = 4'd6;
   localparam logic [SW-1:0] LBWR    = 4'd7;
   localparam logic [SW-1:0] SBWR    = 4'd8;
   localparam logic [SW-1:0] RTYPEEX = 4'd9;
   localparam logic [SW-1:0] RTYPEWR = 4'd10;
   localparam logic [SW-1:0] BEQEX   = 4'd11;
   localparam logic [SW-1:0] JEX     = 4'd12;
   localparam logic [SW-1:0] ADDIEX  = 4'd13;
   localparam logic [SW-1:0] ADDIWR  = 4'd14;

   localparam logic [OPW-1:0] OP_LB   = 6'b100000;
   localparam logic [OPW-1:0] OP_SB   = 6'b101000;
   localparam logic [OPW-1:0] OP_RTYP = 6'b000000;
   localparam logic [OPW-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OPW-1:0] OP_J    = 6'b000010;
   localparam logic [OPW-1:0] OP_ADDI = 6'b001000;

   logic [SW-1:0] state_q;
   logic [SW-1:0] state_d;

   logic       r_memread, r_memwrite, r_alusrca, r_memtoreg;
   logic       r_iord, r_regwrite, r_regdst;
   logic       r_pcwrite, r_pcwritecond;
   logic [1:0] r_pcsource, r_alusrcb, r_aluop;
   logic [3:0] r_irwrite;

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= FETCH1;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = FETCH1;
      case (state_q)
         FETCH1:  state_d = FETCH2;
         FETCH2:  state_d = FETCH3;
         FETCH3:  state_d = FETCH4;
         FETCH4:  state_d = DECODE;
         DECODE: begin
            unique case (1'b1)
               (op == OP_LB):   state_d = MEMADR;
               (op == OP_SB):   state_d = MEMADR;
               (op == OP_RTYP): state_d = RTYPEEX;
               (op == OP_BEQ):  state_d = BEQEX;
               (op == OP_J):    state_d = JEX;
               (op == OP_ADDI): state_d = ADDIEX;
               default:         state_d = FETCH1;
            endcase
         end
         MEMADR:  state_d = (op == OP_LB) ? LBRD : SBWR;
         LBRD:    state_d = LBWR;
         RTYPEEX: state_d = RTYPEWR;
         ADDIEX:  state_d = ADDIWR;
         default: state_d = FETCH1;
      endcase
   end

   always_comb begin
      r_memread     = 1'b0;
      r_memwrite    = 1'b0;
      r_alusrca     = 1'b0;
      r_memtoreg    = 1'b0;
      r_iord        = 1'b0;
      r_regwrite    = 1'b0;
      r_regdst      = 1'b0;
      r_pcwrite     = 1'b0;
      r_pcwritecond = 1'b0;
      r_pcsource    = 2'b00;
      r_alusrcb     = 2'b00;
      r_aluop       = 2'b00;
      r_irwrite     = 4'b0000;
      case (state_q)
         FETCH1, FETCH2, FETCH3, FETCH4: begin
            r_memread = 1'b1;
            r_irwrite = 4'b0001 << state_q[1:0];
            r_alusrcb = 2'b01;
            r_pcwrite = 1'b1;
         end
         DECODE:  r_alusrcb = 2'b11;
         MEMADR: begin
            r_alusrca = 1'b1;
            r_alusrcb = 2'b10;
         end
         LBRD: begin
            r_memread = 1'b1;
            r_iord    = 1'b1;
         end
         LBWR: begin
            r_regwrite = 1'b1;
            r_memtoreg = 1'b1;
         end
         SBWR: begin
            r_memwrite = 1'b1;
            r_iord     = 1'b1;
         end
         RTYPEEX: begin
            r_alusrca = 1'b1;
            r_aluop   = 2'b10;
         end
         RTYPEWR: begin
            r_regwrite = 1'b1;
            r_regdst   = 1'b1;
         end
         BEQEX: begin
            r_alusrca     = 1'b1;
            r_aluop       = 2'b01;
            r_pcsource    = 2'b01;
            r_pcwritecond = 1'b1;
         end
         JEX: begin
            r_pcsource = 2'b10;
            r_pcwrite  = 1'b1;
         end
         ADDIEX: begin
            r_alusrca = 1'b1;
            r_alusrcb = 2'b10;
         end
         ADDIWR:  r_regwrite = 1'b1;
         default: ;
      endcase
   end

   // Reset gates every output combinationally so an aborted op never strobes.
   assign memread  = reset_n & r_memread;
   assign memwrite = reset_n & r_memwrite;
   assign alusrca  = reset_n & r_alusrca;
   assign memtoreg = reset_n & r_memtoreg;
   assign iord     = reset_n & r_iord;
   assign regwrite = reset_n & r_regwrite;
   assign regdst   = reset_n & r_regdst;
   assign pcen     = reset_n & (r_pcwrite | (r_pcwritecond & zero));
   assign pcsource = reset_n ? r_pcsource : 2'b00;
   assign alusrcb  = reset_n ? r_alusrcb  : 2'b00;
   assign aluop    = reset_n ? r_aluop    : 2'b00;
   assign irwrite  = reset_n ? r_irwrite  : 4'b0000;
   assign state    = reset_n ? state_q    : '0;

endmodule

// File: tb/tb_mips8_mc_controller.sv
// Scoreboard bench for mips8_mc_controller.
// Expected state/control vectors are queued per instruction and popped each cycle.
module tb_mips8_mc_controller;

   logic       clk;
   logic       reset_n;
   logic [5:0] op;
   logic       zero;
   logic       memread, memwrite, alusrca, memtoreg, iord;
   logic       pcen, regwrite, regdst;
   logic [1:0] pcsource, alusrcb, aluop;
   logic [3:0] irwrite;
   logic [3:0] state;

   int total = 0;
   int bad   = 0;
   logic [21:0] sbq[$];
   logic watch   = 1'b0;
   logic mw_seen = 1'b0;

   mips8_mc_controller #(.OPW(6), .SW(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .op       (op),
      .zero     (zero),
      .memread  (memread),
      .memwrite (memwrite),
      .alusrca  (alusrca),
      .memtoreg (memtoreg),
      .iord     (iord),
      .pcen     (pcen),
      .regwrite (regwrite),
      .regdst   (regdst),
      .pcsource (pcsource),
      .alusrcb  (alusrcb),
      .aluop    (aluop),
      .irwrite  (irwrite),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge memwrite) if (watch) mw_seen = 1'b1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {state, memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite,
   //  regdst, pcsource, alusrcb, aluop, irwrite}
   function automatic logic [21:0] pk(
      input logic [3:0] s, input logic mr, mw, sa, mtr, io, pe, rw, rd,
      input logic [1:0] ps, sb, ao, input logic [3:0] ir);
      return {s, mr, mw, sa, mtr, io, pe, rw, rd, ps, sb, ao, ir};
   endfunction

   function automatic logic [21:0] exp_vec(input logic [3:0] s,
                                           input logic z);
      case (s)
         4'd0:  return pk(s,1,0,0,0,0,1,0,0,2'b00,2'b01,2'b00,4'b0001);
         4'd1:  return pk(s,1,0,0,0,0,1,0,0,2'b00,2'b01,2'b00,4'b0010);
         4'd2:  return pk(s,1,0,0,0,0,1,0,0,2'b00,2'b01,2'b00,4'b0100);
         4'd3:  return pk(s,1,0,0,0,0,1,0,0,2'b00,2'b01,2'b00,4'b1000);
         4'd4:  return pk(s,0,0,0,0,0,0,0,0,2'b00,2'b11,2'b00,4'b0000);
         4'd5:  return pk(s,0,0,1,0,0,0,0,0,2'b00,2'b10,2'b00,4'b0000);
         4'd6:  return pk(s,1,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,4'b0000);
         4'd7:  return pk(s,0,0,0,1,0,0,1,0,2'b00,2'b00,2'b00,4'b0000);
         4'd8:  return pk(s,0,1,0,0,1,0,0,0,2'b00,2'b00,2'b00,4'b0000);
         4'd9:  return pk(s,0,0,1,0,0,0,0,0,2'b00,2'b00,2'b10,4'b0000);
         4'd10: return pk(s,0,0,0,0,0,0,1,1,2'b00,2'b00,2'b00,4'b0000);
         4'd11: return pk(s,0,0,1,0,0,z,0,0,2'b01,2'b00,2'b01,4'b0000);
         4'd12: return pk(s,0,0,0,0,0,1,0,0,2'b10,2'b00,2'b00,4'b0000);
         4'd13: return pk(s,0,0,1,0,0,0,0,0,2'b00,2'b10,2'b00,4'b0000);
         4'd14: return pk(s,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,4'b0000);
         default: return '0;
      endcase
   endfunction

   function automatic logic [21:0] obs();
      return {state, memread, memwrite, alusrca, memtoreg, iord, pcen,
              regwrite, regdst, pcsource, alusrcb, aluop, irwrite};
   endfunction

   // Runs n cycles (0 = whole instruction); caller is just past a negedge.
   task automatic run_op(input string name, input logic [5:0] o,
                         input logic z, input int n);
      logic [3:0] path[$];
      logic [21:0] e;
      int lim;
      path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      case (o)
         6'b100000: path = {path, 4'd5, 4'd6, 4'd7};
         6'b101000: path = {path, 4'd5, 4'd8};
         6'b000000: path = {path, 4'd9, 4'd10};
         6'b000100: path = {path, 4'd11};
         6'b000010: path = {path, 4'd12};
         6'b001000: path = {path, 4'd13, 4'd14};
         default: ;
      endcase
      lim = (n == 0) ? path.size() : n;
      for (int i = 0; i < lim; i++) sbq.push_back(exp_vec(path[i], z));
      for (int i = 0; i < lim; i++) begin
         op   = (path[i] == 4'd4 || path[i] == 4'd5) ? o : 6'($urandom);
         zero = (path[i] == 4'd11) ? z : 1'($urandom);
         #1;
         e = sbq.pop_front();
         check($sformatf("%s c%0d", name, i), 32'(obs()), 32'(e));
         @(negedge clk);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      op      = 6'd0;
      zero    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check($sformatf("reset c%0d", i), 32'(obs()), 32'd0);
      end
      reset_n = 1'b1;

      run_op("addi",  6'b001000, 1'b0, 0);
      run_op("beq_z1", 6'b000100, 1'b1, 0);
      run_op("beq_z0", 6'b000100, 1'b0, 0);
      run_op("lb",    6'b100000, 1'b0, 0);
      run_op("sb",    6'b101000, 1'b0, 0);
      run_op("rtype", 6'b000000, 1'b0, 0);
      run_op("j",     6'b000010, 1'b0, 0);
      run_op("ill3f", 6'b111111, 1'b0, 0);
      run_op("ill01", 6'b000001, 1'b1, 0);

      watch = 1'b1;
      run_op("sb_abort", 6'b101000, 1'b0, 5);
      op = 6'b101000;
      #1;
      check("abort s5", 32'(obs()), 32'(exp_vec(4'd5, 1'b0)));
      reset_n = 1'b0;
      #1;
      check("abort rst now", 32'(obs()), 32'd0);
      @(negedge clk);
      #1;
      check("abort rst next", 32'(obs()), 32'd0);
      @(negedge clk);
      #1;
      check("abort rst hold", 32'(obs()), 32'd0);
      reset_n = 1'b1;
      run_op("post_abort", 6'b001000, 1'b0, 0);
      watch = 1'b0;
      check("abort no memwrite", 32'(mw_seen), 32'd0);

      for (int k = 0; k < 6; k++) begin
         logic [5:0] ops[6];
         ops = '{6'b100000, 6'b101000, 6'b000000,
                 6'b000100, 6'b000010, 6'b001000};
         run_op($sformatf("mix%0d", k), ops[$urandom_range(0, 5)],
                1'($urandom), 0);
      end

      check("queue empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
